pattern_detect_scheduler: RTL and testbench
===========================================

PATTERN_DETECT_SCHEDULER -- requirements
Module: pattern_detect_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one multiply/pattern-detect datapath.
REQ-002 Parameter A_W, default 11, operand A width.
REQ-003 Parameter B_W, default 11, operand B width.
REQ-004 Parameter C_W, default 21, result width.
REQ-005 Parameter PIPE_LAT, default 2, datapath latency in cycles from issue to result.
REQ-006 Parameter PATTERN, default 21'd36, compare value for match detection.
REQ-007 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 Port rst_n, input, 1, synchronous active-low reset.
REQ-009 Port req_valid, input, N_REQ, per-requester operand valid.
REQ-010 Port req_ready, output, N_REQ, per-requester accept; at most one bit high per cycle.
REQ-011 Port req_a, input, N_REQ*A_W, packed operand A; requester i in slice i.
REQ-012 Port req_b, input, N_REQ*B_W, packed operand B; requester i in slice i.
REQ-013 Port rsp_valid, output, 1, result available.
REQ-014 Port rsp_ready, input, 1, consumer accepts result.
REQ-015 Port rsp_id, output, clog2(N_REQ), index of the requester that owns the result.
REQ-016 Port rsp_c, output, C_W, product result.
REQ-017 Port rsp_match, output, 1, high when rsp_c equals PATTERN.
REQ-018 Port busy, output, 1, high while any operation is in flight or queued.

Function
REQ-019 A transfer occurs on requester i when req_valid[i] and req_ready[i] are both high at a clk edge; requesters hold valid and operands stable until then.
REQ-020 Arbitration is round-robin: the search starts at the index after the last granted requester; after reset, the search starts at index 0.
REQ-021 req_ready[i] is asserted combinationally only for the selected valid requester, and only when credit is available.
REQ-022 Credit: in-flight plus queued results is less than RSP_DEPTH = PIPE_LAT+1; otherwise all req_ready bits stay low.
REQ-023 At most one issue per cycle; issue and response pop in the same cycle are both honoured, and the credit count is unchanged.
REQ-024 Product is unsigned A*B; rsp_c is the low C_W bits.
REQ-025 rsp_match is computed on the truncated rsp_c.
REQ-026 A result enters the response FIFO exactly PIPE_LAT cycles after issue, tagged with the requester id.
REQ-027 rsp_valid is high whenever the FIFO is non-empty; the head pops when rsp_valid and rsp_ready are both high.
REQ-028 The response FIFO never overflows, because credit guarantees space.
REQ-029 Responses return in issue order.
REQ-030 With rsp_ready held high and continuous requests, throughput is one result per cycle.
REQ-031 FIFO read and write pointers wrap modulo RSP_DEPTH.
REQ-032 busy = credit count non-zero.

Reset
REQ-033 While rst_n is low at a clk edge: pipeline valid bits clear, FIFO empties, credit count is 0, and the round-robin pointer is set so index 0 has top priority.
REQ-034 Outputs during and immediately after reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_match=0, busy=0.
REQ-035 Reset mid-operation discards all in-flight and queued results; no stale result appears afterwards.

Structure
REQ-036 A shared package holds the default widths, PIPE_LAT, PATTERN and the clog2-based id width constant.
REQ-037 One sub-module, pd_mult_pipe, holds the registered multiply, truncation, pattern compare and the valid/id shift chain of length PIPE_LAT; the scheduler holds the arbiter, credit counter and response FIFO.

Verification
REQ-038 Single request, requester 0, A=12, B=2, rsp_ready=1 -> after PIPE_LAT+1 cycles: rsp_c=24, rsp_match=0, rsp_id=0.
REQ-039 Single request, requester 2, A=12, B=3 -> rsp_c=36, rsp_match=1, rsp_id=2.
REQ-040 All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one rsp_valid per cycle; ids in grant order.
REQ-041 rsp_ready=0 with four requesters valid -> exactly 3 issues, then all req_ready low; after rsp_ready=1, issue resumes on the cycle the first pop occurs.
REQ-042 A=2047, B=2047 -> rsp_c = 4190209 mod 2^21 = 2093057, rsp_match=0.
REQ-043 rst_n low for one cycle with 2 results queued and 1 in flight -> rsp_valid=0 and busy=0 the next cycle; no result emerges within 5 cycles.

Source files
------------

// File: rtl/pattern_detect_scheduler_pkg.sv
// Shared defaults for the pattern-detect scheduler and its multiply pipe.
// Holds operand/result widths, pipe latency, match pattern and id-width helper.
// No logic; imported by every file of the block.
package pattern_detect_scheduler_pkg;

  localparam int PD_N_REQ    = 4;
  localparam int PD_A_W      = 11;
  localparam int PD_B_W      = 11;
  localparam int PD_C_W      = 21;
  localparam int PD_PIPE_LAT = 2;

  localparam logic [PD_C_W-1:0] PD_PATTERN = 21'd36;

  // Width of an index over n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PD_ID_W = id_width(PD_N_REQ);

endpackage

// File: rtl/pattern_detect_scheduler_mult_pipe.sv
// pd_mult_pipe: registered unsigned multiply, truncation and pattern compare.
// Latency: result and tag appear on res_* exactly PIPE_LAT cycles after issue.
// Backpressure: none; the caller must only issue when downstream space is reserved.
// Ports: clk, rst_n; issue/a/b/id in; res_valid/res_id/res_c/res_match out.
module pd_mult_pipe
  import pattern_detect_scheduler_pkg::*;
#(
  parameter int              A_W      = PD_A_W,
  parameter int              B_W      = PD_B_W,
  parameter int              C_W      = PD_C_W,
  parameter int              ID_W     = PD_ID_W,
  parameter int              PIPE_LAT = PD_PIPE_LAT,
  parameter logic [C_W-1:0]  PATTERN  = C_W'(PD_PATTERN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue,
  input  logic [A_W-1:0]  a,
  input  logic [B_W-1:0]  b,
  input  logic [ID_W-1:0] id,
  output logic            res_valid,
  output logic [ID_W-1:0] res_id,
  output logic [C_W-1:0]  res_c,
  output logic            res_match
);

  // Full product is computed wide enough for either the operands or the result,
  // then truncated; the match is taken on the truncated value.
  localparam int P_W = (A_W + B_W > C_W) ? (A_W + B_W) : C_W;

  logic [P_W-1:0] prod;
  logic [C_W-1:0] prod_c;

  assign prod   = P_W'(a) * P_W'(b);
  assign prod_c = prod[C_W-1:0];

  logic            vld_q   [PIPE_LAT];
  logic [ID_W-1:0] id_q    [PIPE_LAT];
  logic [C_W-1:0]  c_q     [PIPE_LAT];
  logic            match_q [PIPE_LAT];

  // Only the valid chain needs reset; payload follows it blindly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    id_q[0]    <= id;
    c_q[0]     <= prod_c;
    match_q[0] <= (prod_c == PATTERN);
    for (int i = 1; i < PIPE_LAT; i++) begin
      id_q[i]    <= id_q[i-1];
      c_q[i]     <= c_q[i-1];
      match_q[i] <= match_q[i-1];
    end
  end

  assign res_valid = vld_q[PIPE_LAT-1];
  assign res_id    = id_q[PIPE_LAT-1];
  assign res_c     = c_q[PIPE_LAT-1];
  assign res_match = match_q[PIPE_LAT-1];

endmodule

// File: rtl/pattern_detect_scheduler.sv
// Round-robin scheduler sharing one multiply/pattern-detect pipe among N_REQ requesters.
// Latency: a result is visible on rsp_* PIPE_LAT+1 cycles after its request cycle.
// Backpressure: credit-based; req_ready drops when in-flight+queued fills RSP_DEPTH.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b per requester;
//        rsp_valid/rsp_ready/rsp_id/rsp_c/rsp_match response; busy status.
module pattern_detect_scheduler
  import pattern_detect_scheduler_pkg::*;
#(
  parameter int              N_REQ    = PD_N_REQ,
  parameter int              A_W      = PD_A_W,
  parameter int              B_W      = PD_B_W,
  parameter int              C_W      = PD_C_W,
  parameter int              PIPE_LAT = PD_PIPE_LAT,
  parameter logic [C_W-1:0]  PATTERN  = C_W'(PD_PATTERN),
  localparam int             ID_W     = id_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*A_W-1:0]  req_a,
  input  logic [N_REQ*B_W-1:0]  req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [C_W-1:0]        rsp_c,
  output logic                  rsp_match,
  output logic                  busy
);

  localparam int RSP_DEPTH = PIPE_LAT + 1;
  localparam int PTR_W     = id_width(RSP_DEPTH);
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  // ---------------- arbiter ----------------
  logic [ID_W-1:0] last_grant;
  logic            sel_found;
  logic [ID_W-1:0] sel_idx;

  // Index 'off' positions after the last grant, wrapped without a divider.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + 1 + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!sel_found && req_valid[rr_idx(last_grant, i)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_idx(last_grant, i);
      end
    end
  end

  // ---------------- credit ----------------
  logic [CNT_W-1:0] credit_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic             pop;
  logic             credit_ok;
  logic             issue;

  // Outputs are forced quiet while rst_n is low, even on the first reset
  // cycle before the registers have cleared.
  assign rsp_valid = rst_n & (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  // A pop in the same cycle frees a slot, so a full credit count may still issue.
  assign credit_ok = (credit_cnt < CNT_W'(RSP_DEPTH)) | pop;
  assign issue     = rst_n & sel_found & credit_ok;
  assign busy      = rst_n & (credit_cnt != '0);

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credit_cnt <= '0;
      last_grant <= ID_W'(N_REQ - 1);  // index 0 searched first
    end else begin
      if (issue && !pop)      credit_cnt <= credit_cnt + CNT_W'(1);
      else if (pop && !issue) credit_cnt <= credit_cnt - CNT_W'(1);
      if (issue) last_grant <= sel_idx;
    end
  end

  // ---------------- datapath ----------------
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;
  logic            pipe_vld;
  logic [ID_W-1:0] pipe_id;
  logic [C_W-1:0]  pipe_c;
  logic            pipe_match;

  assign sel_a = req_a[int'(sel_idx)*A_W +: A_W];
  assign sel_b = req_b[int'(sel_idx)*B_W +: B_W];

  pd_mult_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .C_W      (C_W),
    .ID_W     (ID_W),
    .PIPE_LAT (PIPE_LAT),
    .PATTERN  (PATTERN)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .a         (sel_a),
    .b         (sel_b),
    .id        (sel_idx),
    .res_valid (pipe_vld),
    .res_id    (pipe_id),
    .res_c     (pipe_c),
    .res_match (pipe_match)
  );

  // ---------------- response FIFO ----------------
  logic [C_W-1:0]  fifo_c     [RSP_DEPTH];
  logic [ID_W-1:0] fifo_id    [RSP_DEPTH];
  logic            fifo_match [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit guarantees a free slot for every result leaving the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (pipe_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      if (pipe_vld && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !pipe_vld) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pipe_vld) begin
      fifo_c[wr_ptr]     <= pipe_c;
      fifo_id[wr_ptr]    <= pipe_id;
      fifo_match[wr_ptr] <= pipe_match;
    end
  end

  // Payload is zeroed when empty so stale storage never shows on the outputs.
  assign rsp_c     = rsp_valid ? fifo_c[rd_ptr]     : '0;
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]    : '0;
  assign rsp_match = rsp_valid ? fifo_match[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_pattern_detect_scheduler.sv
module tb_pattern_detect_scheduler;

  localparam int N     = 4;
  localparam int AW    = 11;
  localparam int BW    = 11;
  localparam int CW    = 21;
  localparam int LAT   = 2;
  localparam int DEPTH = LAT + 1;
  localparam longint PAT = 36;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [CW-1:0]   rsp_c;
  logic            rsp_match;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pattern_detect_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .rsp_match (rsp_match),
    .busy      (busy)
  );

  typedef struct {
    int     req;
    int     a;
    int     b;
    longint c;
    bit     m;
  } vec_t;

  typedef struct {
    int     id;
    longint c;
    bit     m;
    int     t;
  } res_t;

  vec_t vt [8];
  res_t q [$];

  int  rv [N];
  int  ra [N];
  int  rb [N];
  int  lat;
  bit  seen;
  int  mdl_last;
  int  g;
  bit  exp_valid;
  bit  exp_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b);
    req_valid[i]           = v;
    req_a[i*AW +: AW]      = AW'(a);
    req_b[i*BW +: BW]      = BW'(b);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  function automatic int rnd_op();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 12));
    return int'($urandom_range(0, 2047));
  endfunction

  function automatic longint ref_prod(input int a, input int b);
    return (longint'(a) * longint'(b)) % (longint'(1) << CW);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 12,   2,    24,      1'b0};
    vt[1] = '{2, 12,   3,    36,      1'b1};
    vt[2] = '{1, 2047, 2047, 2093057, 1'b0};
    vt[3] = '{3, 6,    6,    36,      1'b1};
    vt[4] = '{1, 0,    5,    0,       1'b0};
    vt[5] = '{3, 2047, 1,    2047,    1'b0};
    vt[6] = '{0, 1024, 1024, 1048576, 1'b0};
    vt[7] = '{2, 1500, 1500, 152848,  1'b0};

    // ---- reset state ----
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    next_cycle();
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id",    rsp_id,    0);
    chk("rst_rsp_c",     rsp_c,     0);
    chk("rst_rsp_match", rsp_match, 0);
    chk("rst_busy",      busy,      0);
    req_valid = '0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_busy",      busy,      0);
    chk("post_rst_req_ready", req_ready, 0);

    // ---- table-driven single transactions ----
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(vt[k].req, 1'b1, vt[k].a, vt[k].b);
      #1;
      chk($sformatf("vec%0d_ready", k), req_ready, 64'(1 << vt[k].req));
      next_cycle();
      req_valid = '0;
      lat  = 0;
      seen = 1'b0;
      for (int w = 1; w <= 10 && !seen; w++) begin
        #1;
        if (rsp_valid) begin
          seen = 1'b1;
          lat  = w;
        end else begin
          next_cycle();
        end
      end
      chk($sformatf("vec%0d_latency", k), lat,       LAT + 1);
      chk($sformatf("vec%0d_c", k),       rsp_c,     vt[k].c);
      chk($sformatf("vec%0d_match", k),   rsp_match, vt[k].m);
      chk($sformatf("vec%0d_id", k),      rsp_id,    vt[k].req);
      next_cycle();
      #1;
      chk($sformatf("vec%0d_drained", k), rsp_valid, 0);
      chk($sformatf("vec%0d_idle", k),    busy,      0);
    end

    // ---- all four requesters, full throughput ----
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 1, 10);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), req_ready, 64'(1 << (k % N)));
      if (k >= LAT + 1) begin
        chk($sformatf("rr_valid%0d", k), rsp_valid, 1);
        chk($sformatf("rr_id%0d", k),    rsp_id,    (k - LAT - 1) % N);
        chk($sformatf("rr_c%0d", k),     rsp_c,     ((k - LAT - 1) % N + 1) * 10);
      end else begin
        chk($sformatf("rr_valid%0d", k), rsp_valid, 0);
      end
      next_cycle();
    end
    req_valid = '0;
    repeat (5) next_cycle();
    #1;
    chk("rr_final_busy", busy, 0);

    // ---- credit exhaustion with rsp_ready low ----
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i + 2, 3);
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("cr_grant%0d", k), req_ready, (k < DEPTH) ? 64'(1 << k) : 64'd0);
      next_cycle();
    end
    #1;
    chk("cr_full_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    #1;
    chk("cr_resume_grant", req_ready, 64'(1 << DEPTH));
    chk("cr_resume_id",    rsp_id,    0);
    chk("cr_resume_c",     rsp_c,     6);
    next_cycle();
    req_valid = '0;
    repeat (6) next_cycle();
    #1;
    chk("cr_final_busy", busy, 0);

    // ---- reset mid-operation ----
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 7, i + 1);
    repeat (DEPTH) next_cycle();
    req_valid = '0;
    next_cycle();
    #1;
    chk("mid_pre_valid", rsp_valid, 1);
    chk("mid_pre_busy",  busy,      1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_rst_valid", rsp_valid, 0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("mid_post_valid", rsp_valid, 0);
    chk("mid_post_busy",  busy,      0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      #1;
      chk($sformatf("mid_no_stale%0d", k), rsp_valid, 0);
    end

    // ---- randomized traffic against a queue-based reference ----
    do_reset();
    mdl_last = N - 1;
    q.delete();
    for (int i = 0; i < N; i++) begin
      rv[i] = 0; ra[i] = 0; rb[i] = 0;
    end
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i] == 0 && $urandom_range(0, 1) == 1) begin
          rv[i] = 1;
          ra[i] = rnd_op();
          rb[i] = rnd_op();
        end
        set_req(i, rv[i] != 0, ra[i], rb[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      // A result is poppable once it has spent LAT cycles in the pipe.
      exp_valid = (q.size() > 0) && (t >= q[0].t + LAT + 1);
      exp_pop   = exp_valid && rsp_ready;
      g = -1;
      if (q.size() < DEPTH || exp_pop) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && rv[(mdl_last + 1 + k) % N] != 0) g = (mdl_last + 1 + k) % N;
        end
      end
      chk($sformatf("rnd_ready_t%0d", t), req_ready, (g >= 0) ? 64'(1 << g) : 64'd0);
      chk($sformatf("rnd_valid_t%0d", t), rsp_valid, exp_valid);
      chk($sformatf("rnd_busy_t%0d", t),  busy,      q.size() != 0);
      if (exp_valid) begin
        chk($sformatf("rnd_id_t%0d", t),    rsp_id,    q[0].id);
        chk($sformatf("rnd_c_t%0d", t),     rsp_c,     q[0].c);
        chk($sformatf("rnd_match_t%0d", t), rsp_match, q[0].m);
      end
      if (exp_pop) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, ref_prod(ra[g], rb[g]), ref_prod(ra[g], rb[g]) == PAT, t});
        mdl_last = g;
        rv[g]    = 0;
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
